// File: rtl/alu_chain_pkg.sv
// Shared types for the byte-serial ALU sequencer: FSM states and rsp_flags bit positions.
package alu_chain_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CMP   = 3;

  function automatic logic [3:0] pack_flags(input logic zero, input logic carry,
                                            input logic ovf, input logic cmp);
    logic [3:0] f;
    f            = '0;
    f[FLG_ZERO]  = zero;
    f[FLG_CARRY] = carry;
    f[FLG_OVF]   = ovf;
    f[FLG_CMP]   = cmp;
    return f;
  endfunction

endpackage

// File: rtl/alu_chain_seq_if.sv
// Request/response bus between the control unit (master) and the ALU sequencer (slave).
interface alu_chain_seq_if #(
  parameter int NBYTES = 2
) ();
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_cins;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cseed;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  modport master (
    output req_valid, req_cins, req_a, req_b, req_cseed, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_cins, req_a, req_b, req_cseed, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_chain_bytesel.sv
// Combinational byte extractor: returns byte idx of a NBYTES-wide word, 0 if idx is out of range.
module alu_chain_bytesel #(
  parameter int NBYTES = 2,
  parameter int IDX_W  = 2
) (
  input  logic [8*NBYTES-1:0] word_dat,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          byte_dat
);

  always_comb begin
    byte_dat = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        byte_dat = word_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/alu_chain_seq.sv
// Drives an external 8-bit ALU LSB-first, one byte per cycle, to do one NBYTES-wide op (ALU_CHAIN_ABORT_EN adds abort).
// rsp_valid rises NBYTES+1 cycles after accept; req_ready only in IDLE; response held until rsp_ready.
module alu_chain_seq
  import alu_chain_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_chain_seq_if.slave       bus,
`ifdef ALU_CHAIN_ABORT_EN
  input  logic                 abort,
`endif
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [7:0]           alu_cins,
  output logic                 alu_oe,
  output logic                 alu_carryin,
  input  logic [7:0]           alu_out,
  input  logic                 alu_carryout,
  input  logic                 alu_overout,
  input  logic                 alu_cmpo
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cins_q, cins_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_acc_q, zero_acc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       flags_q, flags_d;

  logic             run;
  logic             abort_req;
  logic             zero_fin;
  logic [7:0]       a_byte;
  logic [7:0]       b_byte;

`ifdef ALU_CHAIN_ABORT_EN
  assign abort_req = abort && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  alu_chain_bytesel #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_sel_a (
    .word_dat (a_q),
    .idx      (idx_q),
    .byte_dat (a_byte)
  );

  alu_chain_bytesel #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_sel_b (
    .word_dat (b_q),
    .idx      (idx_q),
    .byte_dat (b_byte)
  );

  // ALU pins are only live in RUN; elsewhere the ALU is parked with everything at 0.
  assign run         = (state_q == S_RUN);
  assign alu_oe      = run;
  assign alu_a       = run ? a_byte : 8'h00;
  assign alu_b       = run ? b_byte : 8'h00;
  assign alu_cins    = run ? cins_q : 8'h00;
  assign alu_carryin = run & carry_q;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;

  assign zero_fin = zero_acc_q & (alu_out == 8'h00);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cins_d      = cins_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_acc_d  = zero_acc_q;
    rsp_valid_d = rsp_valid_q;
    flags_d     = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          // carry_q doubles as the byte-0 carry seed, so alu_carryin needs no index mux.
          cins_d     = bus.req_cins;
          a_d        = bus.req_a;
          b_d        = bus.req_b;
          carry_d    = bus.req_cseed;
          idx_d      = '0;
          zero_acc_d = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[8*i +: 8] = alu_out;
          end
        end
        carry_d    = alu_carryout;
        zero_acc_d = zero_fin;
        if (idx_q == LAST_IDX) begin
          flags_d = pack_flags(zero_fin, alu_carryout, alu_overout, alu_cmpo);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (abort_req) begin
      state_d     = S_IDLE;
      rsp_valid_d = 1'b0;
      idx_d       = '0;
      cins_d      = '0;
      a_d         = '0;
      b_d         = '0;
      carry_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cins_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_acc_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cins_q      <= cins_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_acc_q  <= zero_acc_d;
      rsp_valid_q <= rsp_valid_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_chain_seq.sv
// Bench for alu_chain_seq: three instances (NBYTES 1/2/4), each with a behavioural 8-bit ALU on its pins.
module tb_alu_chain_seq;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid_v   [3];
  logic [7:0]  req_cins_v    [3];
  logic [31:0] req_a_v       [3];
  logic [31:0] req_b_v       [3];
  logic        req_cseed_v   [3];
  logic        rsp_ready_v   [3];
  logic        req_ready_v   [3];
  logic        rsp_valid_v   [3];
  logic [31:0] rsp_result_v  [3];
  logic [3:0]  rsp_flags_v   [3];
  logic [7:0]  alu_a_v       [3];
  logic        alu_oe_v      [3];
  logic        alu_carryin_v [3];
`ifdef ALU_CHAIN_ABORT_EN
  logic        abort_v       [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Stand-in for the team ALU: {cmpo, overout, carryout, out}; all zero when oe=0.
  function automatic logic [10:0] alu_fn(input logic [7:0] cins, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin, input logic oe);
    logic [8:0] s;
    logic [7:0] bb, o;
    logic       co, ov;
    s = '0; bb = b; o = '0; co = 1'b0; ov = 1'b0;
    if (oe) begin
      case (cins)
        OP_ADD, OP_SUB: begin
          bb = (cins == OP_SUB) ? ~b : b;
          s  = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
          o  = s[7:0];
          co = s[8];
          ov = (a[7] == bb[7]) && (o[7] != a[7]);
        end
        OP_AND:  o = a & b;
        default: o = '0;
      endcase
    end
    return {oe && (a == b), ov, co, o};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int W  = 8 * NB;
    logic [7:0] alu_a, alu_b, alu_cins, alu_out;
    logic       alu_oe, alu_carryin, alu_carryout, alu_overout, alu_cmpo;

    alu_chain_seq_if #(.NBYTES(NB)) bus ();

    assign bus.req_valid    = req_valid_v[g];
    assign bus.req_cins     = req_cins_v[g];
    assign bus.req_a        = req_a_v[g][W-1:0];
    assign bus.req_b        = req_b_v[g][W-1:0];
    assign bus.req_cseed    = req_cseed_v[g];
    assign bus.rsp_ready    = rsp_ready_v[g];
    assign req_ready_v[g]   = bus.req_ready;
    assign rsp_valid_v[g]   = bus.rsp_valid;
    assign rsp_result_v[g]  = 32'(bus.rsp_result);
    assign rsp_flags_v[g]   = bus.rsp_flags;
    assign alu_a_v[g]       = alu_a;
    assign alu_oe_v[g]      = alu_oe;
    assign alu_carryin_v[g] = alu_carryin;

    alu_chain_seq #(.NBYTES(NB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
`ifdef ALU_CHAIN_ABORT_EN
      .abort        (abort_v[g]),
`endif
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_cins     (alu_cins),
      .alu_oe       (alu_oe),
      .alu_carryin  (alu_carryin),
      .alu_out      (alu_out),
      .alu_carryout (alu_carryout),
      .alu_overout  (alu_overout),
      .alu_cmpo     (alu_cmpo)
    );

    always_comb {alu_cmpo, alu_overout, alu_carryout, alu_out} =
      alu_fn(alu_cins, alu_a, alu_b, alu_carryin, alu_oe);
  end

  function automatic int nb_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 2 : 4);
  endfunction

  // Word-level reference: {cmp, ovf, carry, zero, result} straight from the arithmetic.
  function automatic logic [35:0] ref_op(input int nb, input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cseed);
    logic [63:0] mask, aa, bo, bb, sum;
    logic [31:0] res;
    logic        carry, ovf, cmp, zero;
    int          w;
    w     = 8 * nb;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'd0, a} & mask;
    bo    = {32'd0, b} & mask;
    bb    = bo;
    carry = 1'b0;
    ovf   = 1'b0;
    if (op == OP_AND) begin
      sum = aa & bb;
    end else begin
      if (op == OP_SUB) bb = ~bo & mask;
      sum   = aa + bb + {63'd0, cseed};
      carry = sum[w];
      ovf   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    end
    res  = 32'(sum & mask);
    zero = (res == 32'd0);
    cmp  = ((aa >> (w - 8)) & 64'hFF) == ((bo >> (w - 8)) & 64'hFF);
    return {cmp, ovf, carry, zero, res};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called and returns on a negedge; on return the accept edge has passed and byte 0 is on the pins.
  task automatic start_op(input int sel, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cseed);
    int wt;
    wt = 0;
    while (!req_ready_v[sel] && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("req_ready_before_accept", 64'(req_ready_v[sel]), 64'd1);
    req_cins_v[sel]  = op;
    req_a_v[sel]     = a;
    req_b_v[sel]     = b;
    req_cseed_v[sel] = cseed;
    rsp_ready_v[sel] = 1'b0;
    req_valid_v[sel] = 1'b1;
    @(negedge clk);
    req_valid_v[sel] = 1'b0;
  endtask

  task automatic wait_rsp(input int sel, output int lat, output int oe_cnt, output logic [3:0] cin_hist);
    lat      = -1;
    oe_cnt   = 0;
    cin_hist = '0;
    for (int c = 1; c <= 40; c++) begin
      if (alu_oe_v[sel]) begin
        if (oe_cnt < 4) cin_hist[oe_cnt] = alu_carryin_v[sel];
        oe_cnt++;
      end
      @(negedge clk);
      if (rsp_valid_v[sel]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_rsp(input int sel);
    rsp_ready_v[sel] = 1'b1;
    @(negedge clk);
    rsp_ready_v[sel] = 1'b0;
  endtask

  task automatic run_op(input int sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cseed, output logic [31:0] res, output logic [3:0] fl,
                        output int lat, output int oe_cnt, output logic [3:0] cin_hist);
    start_op(sel, op, a, b, cseed);
    wait_rsp(sel, lat, oe_cnt, cin_hist);
    res = rsp_result_v[sel];
    fl  = rsp_flags_v[sel];
    if (lat >= 0) finish_rsp(sel);
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cseed;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;   // {cmp, ovf, carry, zero}
    logic [3:0]  exp_cin;  // alu_carryin seen on byte 0..3
  } vec_t;

  vec_t vecs[10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, r_hold;
    logic [3:0]  fl, cin_hist, f_hold;
    logic [35:0] exp;
    logic [31:0] ra, rb, mask;
    logic [7:0]  op;
    logic        cs, seen;
    int          lat, oe_cnt;

    vecs[0] = '{1, OP_ADD, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 4'b1000, 4'b0010};
    vecs[1] = '{1, OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 4'b0011, 4'b0010};
    vecs[2] = '{1, OP_ADD, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 4'b0100, 4'b0010};
    vecs[3] = '{1, OP_SUB, 32'h0100, 32'h0001, 1'b1, 32'h00FF, 4'b0010, 4'b0001};
    vecs[4] = '{1, OP_AND, 32'hF0F0, 32'h0F0F, 1'b0, 32'h0000, 4'b0001, 4'b0000};
    vecs[5] = '{1, OP_AND, 32'h1234, 32'h1234, 1'b0, 32'h1234, 4'b1000, 4'b0000};
    vecs[6] = '{0, OP_ADD, 32'h00FF, 32'h0001, 1'b0, 32'h0000, 4'b0011, 4'b0000};
    vecs[7] = '{0, OP_ADD, 32'h007F, 32'h0001, 1'b0, 32'h0080, 4'b0100, 4'b0000};
    vecs[8] = '{2, OP_ADD, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 4'b1000, 4'b0010};
    vecs[9] = '{2, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0011, 4'b1110};

    for (int g = 0; g < 3; g++) begin
      req_valid_v[g] = 1'b0;
      req_cins_v[g]  = '0;
      req_a_v[g]     = '0;
      req_b_v[g]     = '0;
      req_cseed_v[g] = 1'b0;
      rsp_ready_v[g] = 1'b0;
`ifdef ALU_CHAIN_ABORT_EN
      abort_v[g]     = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_req_ready_%0d", g),  64'(req_ready_v[g]),  64'd1);
      chk($sformatf("reset_rsp_valid_%0d", g),  64'(rsp_valid_v[g]),  64'd0);
      chk($sformatf("reset_rsp_result_%0d", g), 64'(rsp_result_v[g]), 64'd0);
      chk($sformatf("reset_rsp_flags_%0d", g),  64'(rsp_flags_v[g]),  64'd0);
      chk($sformatf("reset_alu_oe_%0d", g),     64'(alu_oe_v[g]),     64'd0);
      chk($sformatf("reset_alu_a_%0d", g),      64'(alu_a_v[g]),      64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cseed, res, fl, lat, oe_cnt, cin_hist);
      chk($sformatf("vec%0d_result", i),  64'(res),      64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flags", i),   64'(fl),       64'(vecs[i].exp_fl));
      chk($sformatf("vec%0d_latency", i), 64'(lat),      64'(nb_of(vecs[i].sel) + 1));
      chk($sformatf("vec%0d_oe_bytes", i), 64'(oe_cnt),  64'(nb_of(vecs[i].sel)));
      chk($sformatf("vec%0d_carryin", i), 64'(cin_hist), 64'(vecs[i].exp_cin));
    end

    for (int sel = 0; sel < 3; sel++) begin
      mask = (nb_of(sel) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb_of(sel))) - 32'd1);
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(2, 0))
          0:       op = OP_ADD;
          1:       op = OP_SUB;
          default: op = OP_AND;
        endcase
        ra = $urandom & mask;
        rb = (k % 5 == 0) ? ra : ($urandom & mask);
        cs = 1'($urandom_range(1, 0));
        exp = ref_op(nb_of(sel), op, ra, rb, cs);
        run_op(sel, op, ra, rb, cs, res, fl, lat, oe_cnt, cin_hist);
        chk($sformatf("rand%0d_%0d_result", sel, k),  64'(res), 64'(exp[31:0]));
        chk($sformatf("rand%0d_%0d_flags", sel, k),   64'(fl),  64'(exp[35:32]));
        chk($sformatf("rand%0d_%0d_latency", sel, k), 64'(lat), 64'(nb_of(sel) + 1));
      end
    end

    // Response held under backpressure; a second request meanwhile must not be taken.
    start_op(1, OP_ADD, 32'h1111, 32'h2222, 1'b0);
    wait_rsp(1, lat, oe_cnt, cin_hist);
    chk("hold_latency", 64'(lat), 64'd3);
    r_hold = rsp_result_v[1];
    f_hold = rsp_flags_v[1];
    chk("hold_first_result", 64'(r_hold), 64'h3333);
    for (int c = 0; c < 5; c++) begin
      req_a_v[1]     = 32'hAAAA;
      req_valid_v[1] = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d_req_ready", c), 64'(req_ready_v[1]),  64'd0);
      chk($sformatf("hold%0d_rsp_valid", c), 64'(rsp_valid_v[1]),  64'd1);
      chk($sformatf("hold%0d_result", c),    64'(rsp_result_v[1]), 64'h3333);
      chk($sformatf("hold%0d_flags", c),     64'(rsp_flags_v[1]),  64'(f_hold));
    end
    req_valid_v[1] = 1'b0;
    finish_rsp(1);
    chk("hold_release_rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
    chk("hold_release_req_ready", 64'(req_ready_v[1]), 64'd1);
    run_op(1, OP_ADD, 32'h0001, 32'h0001, 1'b0, res, fl, lat, oe_cnt, cin_hist);
    chk("after_hold_result",  64'(res), 64'h0002);
    chk("after_hold_latency", 64'(lat), 64'd3);

    // Reset mid-RUN drops the operation without a response.
    start_op(1, OP_ADD, 32'h00FF, 32'h0001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
    chk("midrun_reset_alu_oe",    64'(alu_oe_v[1]),    64'd0);
    chk("midrun_reset_req_ready", 64'(req_ready_v[1]), 64'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_v[1]) seen = 1'b1;
    end
    chk("midrun_reset_no_rsp", 64'(seen), 64'd0);

`ifdef ALU_CHAIN_ABORT_EN
    start_op(1, OP_ADD, 32'h00FF, 32'h0001, 1'b0);
    abort_v[1] = 1'b1;
    @(negedge clk);
    abort_v[1] = 1'b0;
    chk("abort_run_rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
    chk("abort_run_req_ready", 64'(req_ready_v[1]), 64'd1);
    chk("abort_run_alu_oe",    64'(alu_oe_v[1]),    64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_v[1]) seen = 1'b1;
    end
    chk("abort_run_no_rsp", 64'(seen), 64'd0);

    start_op(1, OP_ADD, 32'h1234, 32'h0001, 1'b0);
    wait_rsp(1, lat, oe_cnt, cin_hist);
    chk("abort_done_latency", 64'(lat), 64'd3);
    abort_v[1]     = 1'b1;
    rsp_ready_v[1] = 1'b1;
    @(negedge clk);
    abort_v[1]     = 1'b0;
    rsp_ready_v[1] = 1'b0;
    chk("abort_done_rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
    chk("abort_done_req_ready", 64'(req_ready_v[1]), 64'd1);
    run_op(1, OP_ADD, 32'h0001, 32'h0002, 1'b0, res, fl, lat, oe_cnt, cin_hist);
    chk("after_abort_result", 64'(res), 64'h0003);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
